// File: rtl/scpad_dram_row_beats.sv
// scpad_dram_row_beats
//   Splits one scratchpad row transfer into DRAM-bus-sized beats and reassembles
//   read responses (which may return in any order) back into a row.
//
//   Ports
//     CLK, nRST                    clock, asynchronous active-low reset
//     row_*                        row request from the scratchpad backend (valid/ready)
//     dram_req_*                   one beat per handshake towards the DRAM controller
//     dram_res_*                   response strobe (no backpressure), ID = {tag, beat}
//     done_*                       one-cycle completion pulse with the assembled row
//     err                          sticky flag for any response that does not fit
//                                  the row in flight
module scpad_dram_row_beats #(
  parameter int ELEM_BITS       = 16,
  parameter int NUM_COLS        = 32,
  parameter int BUS_BITS        = 64,
  parameter int DRAM_ADDR_WIDTH = 32,
  parameter int DRAM_ID_WIDTH   = 8,
  localparam int EPB            = BUS_BITS / ELEM_BITS,
  localparam int NUM_BEATS      = NUM_COLS / EPB,
  localparam int BEAT_W         = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1,
  localparam int COL_W          = $clog2(NUM_COLS),
  localparam int TAG_W          = DRAM_ID_WIDTH - BEAT_W
) (
  input  logic                          CLK,
  input  logic                          nRST,
  input  logic                          row_valid,
  output logic                          row_ready,
  input  logic                          row_write,
  input  logic [DRAM_ADDR_WIDTH-1:0]    row_addr,
  input  logic [COL_W-1:0]              row_num_cols,
  input  logic [TAG_W-1:0]              row_tag,
  input  logic [NUM_COLS*ELEM_BITS-1:0] row_wdata,
  output logic                          dram_req_valid,
  input  logic                          dram_req_ready,
  output logic                          dram_req_write,
  output logic [DRAM_ID_WIDTH-1:0]      dram_req_id,
  output logic [DRAM_ADDR_WIDTH-1:0]    dram_req_addr,
  output logic [EPB-1:0]                dram_req_mask,
  output logic [BUS_BITS-1:0]           dram_req_wdata,
  input  logic                          dram_res_valid,
  input  logic                          dram_res_write,
  input  logic [DRAM_ID_WIDTH-1:0]      dram_res_id,
  input  logic [BUS_BITS-1:0]           dram_res_rdata,
  output logic                          done_valid,
  output logic                          done_write,
  output logic [TAG_W-1:0]              done_tag,
  output logic [NUM_COLS*ELEM_BITS-1:0] done_rdata,
  output logic [NUM_COLS-1:0]           done_mask,
  output logic                          err
);

  localparam int NW         = COL_W + 1;   // holds n in 1..NUM_COLS
  localparam int BW         = BEAT_W + 1;  // holds beat counts in 0..NUM_BEATS
  localparam int RB         = 1 << BEAT_W; // one received bit per encodable beat index
  localparam int ROW_BITS   = NUM_COLS * ELEM_BITS;
  localparam int LOG_EPB    = $clog2(EPB);
  localparam int BEAT_BYTES = BUS_BITS / 8;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_e;

  state_e                     state_q, state_d;
  logic                       write_q, write_d;
  logic [TAG_W-1:0]           tag_q, tag_d;
  logic [DRAM_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [NW-1:0]              n_q, n_d;
  logic [BW-1:0]              nb_q, nb_d;
  logic [BW-1:0]              b_q, b_d;
  logic [ROW_BITS-1:0]        wdata_q, wdata_d;
  logic [ROW_BITS-1:0]        rdata_q, rdata_d;
  logic [RB-1:0]              rcvd_q, rcvd_d;
  logic                       err_q, err_d;

  logic [NW-1:0]              n_round;
  logic [BEAT_W-1:0]          res_idx;
  logic [TAG_W-1:0]           res_tag;
  logic                       res_ok;
  logic [BUS_BITS-1:0]        res_masked;
  logic [RB-1:0]              need_mask;

  assign res_idx   = dram_res_id[BEAT_W-1:0];
  assign res_tag   = dram_res_id[DRAM_ID_WIDTH-1:BEAT_W];
  assign res_ok    = (res_tag == tag_q) && ({1'b0, res_idx} < nb_q) &&
                     (dram_res_write == write_q) && !rcvd_q[res_idx];
  // Low nb bits set; wraps to all-ones when nb equals RB.
  assign need_mask = (RB'(1) << nb_q) - RB'(1);

  // Read data for elements past the row's active length is zeroed before storing.
  always_comb begin
    res_masked = dram_res_rdata;
    for (int e = 0; e < EPB; e++) begin
      if (int'(res_idx) * EPB + e >= int'(n_q)) res_masked[e*ELEM_BITS +: ELEM_BITS] = '0;
    end
  end

  always_comb begin
    // NOTE: every variable gets its hold value first so no branch leaves one
    // unassigned, which would otherwise infer a latch.
    state_d = state_q;
    write_d = write_q;
    tag_d   = tag_q;
    addr_d  = addr_q;
    n_d     = n_q;
    nb_d    = nb_q;
    b_d     = b_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    rcvd_d  = rcvd_q;
    err_d   = err_q;
    n_round = '0;

    unique case (state_q)
      S_IDLE: begin
        if (dram_res_valid) err_d = 1'b1;
        if (row_valid) begin
          write_d = row_write;
          tag_d   = row_tag;
          addr_d  = row_addr;
          wdata_d = row_wdata;
          n_d     = (row_num_cols == '0) ? NW'(NUM_COLS) : {1'b0, row_num_cols};
          n_round = n_d + NW'(EPB - 1);
          nb_d    = BW'(n_round >> LOG_EPB);
          b_d     = '0;
          rdata_d = '0;
          rcvd_d  = '0;
          state_d = S_ISSUE;
        end
      end

      S_ISSUE, S_WAIT: begin
        if (state_q == S_ISSUE && dram_req_ready) begin
          b_d = b_q + BW'(1);
          if (b_q == nb_q - BW'(1)) state_d = S_WAIT;
        end
        if (dram_res_valid) begin
          if (res_ok) begin
            rcvd_d[res_idx] = 1'b1;
            if (!write_q) rdata_d[int'(res_idx)*BUS_BITS +: BUS_BITS] = res_masked;
          end else begin
            err_d = 1'b1;
          end
        end
        // Completion wins even if issue is still in progress.
        if ((rcvd_d & need_mask) == need_mask) state_d = S_DONE;
      end

      S_DONE: begin
        if (dram_res_valid) err_d = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    row_ready      = (state_q == S_IDLE);
    dram_req_valid = 1'b0;
    dram_req_write = 1'b0;
    dram_req_id    = '0;
    dram_req_addr  = '0;
    dram_req_mask  = '0;
    dram_req_wdata = '0;
    done_valid     = 1'b0;
    done_write     = 1'b0;
    done_tag       = '0;
    done_rdata     = '0;
    done_mask      = '0;
    err            = err_q;

    if (state_q == S_ISSUE) begin
      dram_req_valid = 1'b1;
      dram_req_write = write_q;
      dram_req_id    = {tag_q, b_q[BEAT_W-1:0]};
      dram_req_addr  = addr_q + DRAM_ADDR_WIDTH'(b_q) * DRAM_ADDR_WIDTH'(BEAT_BYTES);
      for (int e = 0; e < EPB; e++) dram_req_mask[e] = (int'(b_q) * EPB + e) < int'(n_q);
      if (write_q) dram_req_wdata = wdata_q[int'(b_q[BEAT_W-1:0])*BUS_BITS +: BUS_BITS];
    end

    if (state_q == S_DONE) begin
      done_valid = 1'b1;
      done_write = write_q;
      done_tag   = tag_q;
      done_rdata = write_q ? '0 : rdata_q;
      for (int i = 0; i < NUM_COLS; i++) done_mask[i] = i < int'(n_q);
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= S_IDLE;
      write_q <= 1'b0;
      tag_q   <= '0;
      addr_q  <= '0;
      n_q     <= '0;
      nb_q    <= '0;
      b_q     <= '0;
      // NOTE: the row buffers are plain flops, not a RAM, so they can and do get
      // cleared here; that keeps every data output a defined zero out of reset.
      wdata_q <= '0;
      rdata_q <= '0;
      rcvd_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values
      // regardless of statement order.
      state_q <= state_d;
      write_q <= write_d;
      tag_q   <= tag_d;
      addr_q  <= addr_d;
      n_q     <= n_d;
      nb_q    <= nb_d;
      b_q     <= b_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      rcvd_q  <= rcvd_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_scpad_dram_row_beats.sv
// Directed + randomized bench for scpad_dram_row_beats. Expected beats and the
// assembled row come from a small arithmetic model of the row-to-beat rules.
module tb_scpad_dram_row_beats;

  localparam int EB     = 16;
  localparam int NC     = 32;
  localparam int BB     = 64;
  localparam int AW     = 32;
  localparam int IW     = 8;
  localparam int EPB    = 4;
  localparam int NB     = 8;
  localparam int BEAT_W = 3;
  localparam int TW     = 5;
  localparam int CW     = 5;

  logic               CLK = 1'b0;
  logic               nRST;
  logic               row_valid, row_ready, row_write;
  logic [AW-1:0]      row_addr;
  logic [CW-1:0]      row_num_cols;
  logic [TW-1:0]      row_tag;
  logic [NC*EB-1:0]   row_wdata;
  logic               dram_req_valid, dram_req_ready, dram_req_write;
  logic [IW-1:0]      dram_req_id;
  logic [AW-1:0]      dram_req_addr;
  logic [EPB-1:0]     dram_req_mask;
  logic [BB-1:0]      dram_req_wdata;
  logic               dram_res_valid, dram_res_write;
  logic [IW-1:0]      dram_res_id;
  logic [BB-1:0]      dram_res_rdata;
  logic               done_valid, done_write;
  logic [TW-1:0]      done_tag;
  logic [NC*EB-1:0]   done_rdata;
  logic [NC-1:0]      done_mask;
  logic               err;

  int n_vec = 0;
  int n_err = 0;
  logic exp_err = 1'b0;

  always #5 CLK = ~CLK;

  scpad_dram_row_beats dut (
    .CLK(CLK), .nRST(nRST),
    .row_valid(row_valid), .row_ready(row_ready), .row_write(row_write),
    .row_addr(row_addr), .row_num_cols(row_num_cols), .row_tag(row_tag),
    .row_wdata(row_wdata),
    .dram_req_valid(dram_req_valid), .dram_req_ready(dram_req_ready),
    .dram_req_write(dram_req_write), .dram_req_id(dram_req_id),
    .dram_req_addr(dram_req_addr), .dram_req_mask(dram_req_mask),
    .dram_req_wdata(dram_req_wdata),
    .dram_res_valid(dram_res_valid), .dram_res_write(dram_res_write),
    .dram_res_id(dram_res_id), .dram_res_rdata(dram_res_rdata),
    .done_valid(done_valid), .done_write(done_write), .done_tag(done_tag),
    .done_rdata(done_rdata), .done_mask(done_mask), .err(err)
  );

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_values(input string pfx);
    check({pfx, "_row_ready"}, row_ready, 1);
    check({pfx, "_req"}, {dram_req_valid, dram_req_write, dram_req_id, dram_req_addr,
                          dram_req_mask, dram_req_wdata}, 0);
    check({pfx, "_done"}, {done_valid, done_write, done_tag, done_mask}, 0);
    check({pfx, "_done_rdata"}, done_rdata, 0);
    check({pfx, "_err"}, err, 0);
  endtask

  // order: 0 random, 1 descending, 2 ascending. bad injects a wrong-tag response
  // before the first one and a duplicate right after the first one.
  task automatic run_row(input logic wr, input logic [AW-1:0] addr, input logic [CW-1:0] ncols,
                         input logic [TW-1:0] tag, input int stall_beat, input int stall_cyc,
                         input int order, input bit bad);
    logic [NC*EB-1:0] wdata, exp_rdata;
    logic [BB-1:0]    rd [NB];
    logic [BB-1:0]    exp_wd;
    logic [EPB-1:0]   exp_mask;
    logic [IW-1:0]    exp_id;
    logic [NC:0]      dm;
    int perm [NB];
    int n, nb, cnt, stall_left, guard, act, j, t;

    n  = (ncols == 0) ? NC : int'(ncols);
    nb = (n + EPB - 1) / EPB;
    for (int i = 0; i < NC*EB/32; i++) wdata[i*32 +: 32] = $urandom;
    for (int b = 0; b < NB; b++) rd[b] = {$urandom, $urandom};

    @(negedge CLK);
    check("row_ready_idle", row_ready, 1);
    row_valid = 1'b1; row_write = wr; row_addr = addr; row_num_cols = ncols;
    row_tag = tag; row_wdata = wdata;
    @(negedge CLK);
    row_valid = 1'b0;
    check("req_first_cycle", dram_req_valid, 1);

    cnt = 0; stall_left = stall_cyc; guard = 0;
    while (cnt < nb && guard < 200) begin
      if (dram_req_valid) begin
        act = n - cnt*EPB;
        if (act > EPB) act = EPB;
        exp_mask = EPB'((1 << act) - 1);
        exp_wd   = wr ? wdata[cnt*BB +: BB] : '0;
        exp_id   = {tag, BEAT_W'(cnt)};
        check($sformatf("beat%0d", cnt),
              {dram_req_write, dram_req_id, dram_req_addr, dram_req_mask, dram_req_wdata},
              {wr, exp_id, addr + AW'(cnt*(BB/8)), exp_mask, exp_wd});
        if (cnt == stall_beat && stall_left > 0) begin
          dram_req_ready = 1'b0;
          stall_left--;
        end else begin
          dram_req_ready = 1'b1;
          cnt++;
        end
      end else begin
        dram_req_ready = 1'b0;
      end
      @(negedge CLK);
      guard++;
    end
    dram_req_ready = 1'b0;
    check("beat_count", cnt, nb);
    check("no_extra_beat", dram_req_valid, 0);

    for (int k = 0; k < nb; k++) perm[k] = (order == 1) ? nb - 1 - k : k;
    if (order == 0) begin
      for (int k = nb - 1; k > 0; k--) begin
        j = int'($urandom_range(k, 0));
        t = perm[k]; perm[k] = perm[j]; perm[j] = t;
      end
    end

    if (bad) begin
      dram_res_valid = 1'b1; dram_res_write = wr;
      dram_res_id = {tag ^ TW'(1), BEAT_W'(0)}; dram_res_rdata = '1;
      @(negedge CLK);
    end
    for (int k = 0; k < nb; k++) begin
      check($sformatf("no_early_done%0d", k), done_valid, 0);
      dram_res_valid = 1'b1; dram_res_write = wr;
      dram_res_id = {tag, BEAT_W'(perm[k])}; dram_res_rdata = rd[perm[k]];
      @(negedge CLK);
      if (bad && k == 0) begin
        dram_res_rdata = ~rd[perm[k]];  // duplicate must not overwrite
        @(negedge CLK);
      end
    end
    dram_res_valid = 1'b0;

    exp_rdata = '0;
    if (!wr) for (int i = 0; i < n; i++) exp_rdata[i*EB +: EB] = rd[i/EPB][(i%EPB)*EB +: EB];
    dm = (33'd1 << n) - 33'd1;
    check("done_valid", done_valid, 1);
    check("done_fields", {done_write, done_tag, done_mask}, {wr, tag, dm[NC-1:0]});
    check("done_rdata", done_rdata, exp_rdata);
    @(negedge CLK);
    check("done_one_cycle", done_valid, 0);
    check("row_ready_back", row_ready, 1);
    if (bad) exp_err = 1'b1;
    check("err_flag", err, exp_err);
  endtask

  initial begin
    nRST = 1'b0; row_valid = 1'b0; row_write = 1'b0; row_addr = '0; row_num_cols = '0;
    row_tag = '0; row_wdata = '0; dram_req_ready = 1'b0; dram_res_valid = 1'b0;
    dram_res_write = 1'b0; dram_res_id = '0; dram_res_rdata = '0;
    #12;
    check_reset_values("reset");
    @(negedge CLK);
    nRST = 1'b1;

    // Full write, 8 beats at 0x1000.., IDs 0x28..0x2F.
    run_row(1'b1, 32'h0000_1000, 5'd0, 5'd5, -1, 0, 0, 1'b0);
    // Partial read n=6, responses beat1 then beat0.
    run_row(1'b0, 32'h0000_2000, 5'd6, 5'd3, -1, 0, 1, 1'b0);
    // Ready held low 3 cycles on beat 2.
    run_row(1'b1, 32'h0000_4000, 5'd0, 5'd17, 2, 3, 0, 1'b0);
    // Address wrap.
    run_row(1'b0, 32'hFFFF_FFF8, 5'd0, 5'd30, -1, 0, 0, 1'b0);
    // Odd lengths at the beat boundary.
    run_row(1'b0, 32'h0000_0100, 5'd1, 5'd1, -1, 0, 0, 1'b0);
    run_row(1'b0, 32'h0000_0200, 5'd31, 5'd2, 7, 1, 0, 1'b0);

    for (int r = 0; r < 8; r++) begin
      run_row(1'($urandom), $urandom, CW'($urandom), TW'($urandom),
              int'($urandom_range(NB - 1, 0)), int'($urandom_range(2, 0)), 0, 1'b0);
    end

    // Wrong tag and duplicate response; row still completes.
    run_row(1'b0, 32'h0000_8000, 5'd0, 5'd12, -1, 0, 2, 1'b1);
    // Response while idle; err stays set.
    @(negedge CLK);
    dram_res_valid = 1'b1; dram_res_write = 1'b0; dram_res_id = 8'h61;
    @(negedge CLK);
    dram_res_valid = 1'b0;
    check("err_sticky_idle", err, 1);

    // Reset during ISSUE after 3 accepted beats.
    @(negedge CLK);
    row_valid = 1'b1; row_write = 1'b1; row_addr = 32'h0000_3000; row_num_cols = '0;
    row_tag = 5'd9; row_wdata = {16{32'hA5A5_0000}};
    @(negedge CLK);
    row_valid = 1'b0; dram_req_ready = 1'b1;
    repeat (3) @(negedge CLK);
    dram_req_ready = 1'b0;
    check("beat3_before_reset", {dram_req_valid, dram_req_id}, {1'b1, 8'h4B});
    #2 nRST = 1'b0;
    #1 check_reset_values("midrow_reset");
    @(negedge CLK);
    nRST = 1'b1;
    exp_err = 1'b0;
    run_row(1'b1, 32'h0000_5000, 5'd0, 5'd9, -1, 0, 0, 1'b0);

    // Stale response of the abandoned row, now arriving in IDLE.
    @(negedge CLK);
    dram_res_valid = 1'b1; dram_res_write = 1'b1; dram_res_id = 8'h4B;
    @(negedge CLK);
    dram_res_valid = 1'b0;
    check("err_stale_after_reset", err, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
